// File: rtl/operand_feeder.sv
// operand_feeder: packs a serial word stream into INPUT_NUM-lane vectors, with flush of partial groups
module operand_feeder #(
    parameter int INPUT_NUM = 4,
    parameter int WIDTH     = 32,
    localparam int IW = $clog2(INPUT_NUM),
    localparam int CW = $clog2(INPUT_NUM + 1)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [WIDTH-1:0]                    s_data,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic                                flush,
    output logic                                flush_ack,
    output logic [INPUT_NUM-1:0][WIDTH-1:0]     m_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [CW-1:0]                       m_count
);
    logic [IW-1:0]                  fill_idx;
    logic [INPUT_NUM-1:0][WIDTH-1:0] asm_buf;
    logic [INPUT_NUM-1:0][WIDTH-1:0] merged;
    logic [CW-1:0]                  filled;
    logic                           slot_free;
    logic                           in_xfer;
    logic                           last;
    logic                           flush_go;
    logic                           emit;

    assign slot_free = !m_valid || m_ready;
    assign s_ready   = (fill_idx != IW'(INPUT_NUM - 1)) || slot_free;
    assign in_xfer   = s_valid && s_ready;
    assign last      = in_xfer && (fill_idx == IW'(INPUT_NUM - 1));
    assign filled    = CW'(fill_idx) + CW'(in_xfer);
    // flush_ack high means the held request was already consumed last edge
    assign flush_go  = flush && !flush_ack && (last || filled == '0 || slot_free);
    assign emit      = last || (flush_go && filled != '0);

    // buffer contents as they would be after this cycle's input word lands
    always_comb begin
        merged = asm_buf;
        if (in_xfer) merged[fill_idx] = s_data;
    end

    // assembly buffer is cleared on every emit so unfilled lanes read as zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_buf  <= '0;
            fill_idx <= '0;
        end else if (emit) begin
            asm_buf  <= '0;
            fill_idx <= '0;
        end else if (in_xfer) begin
            asm_buf  <= merged;
            fill_idx <= fill_idx + 1'b1;
        end
    end

    // output slot: load only when free, otherwise hold until consumed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_data    <= '0;
            m_count   <= '0;
            m_valid   <= 1'b0;
            flush_ack <= 1'b0;
        end else begin
            flush_ack <= flush_go;
            if (emit) begin
                m_data  <= merged;
                m_count <= filled;
                m_valid <= 1'b1;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_operand_feeder.sv
// tb_operand_feeder: scoreboard-based bench for operand_feeder
module tb_operand_feeder;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int CW = $clog2(N + 1);

    logic                 clk;
    logic                 rst;
    logic [W-1:0]         s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 flush;
    logic                 flush_ack;
    logic [N-1:0][W-1:0]  m_data;
    logic                 m_valid;
    logic                 m_ready;
    logic [CW-1:0]        m_count;

    int checks = 0;
    int failures = 0;

    logic [N*W-1:0] exp_d[$];
    int             exp_c[$];
    int             grp[$];

    operand_feeder #(.INPUT_NUM(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .flush(flush), .flush_ack(flush_ack), .m_data(m_data), .m_valid(m_valid),
        .m_ready(m_ready), .m_count(m_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // close the current model group into an expected vector, zero-filling empty lanes
    task automatic push_vec();
        logic [N*W-1:0] v;
        v = '0;
        for (int k = 0; k < grp.size(); k++) v[k*W +: W] = W'(grp[k]);
        exp_d.push_back(v);
        exp_c.push_back(grp.size());
        grp.delete();
    endtask

    task automatic model_word(input int w);
        grp.push_back(w);
        if (grp.size() == N) push_vec();
    endtask

    // present words back to back; each must be accepted in its own cycle
    task automatic stream_words(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = W'(first + i);
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b1) begin
                failures++;
                $display("FAIL stream_s_ready word=%0d got=%b want=1", first + i, s_ready);
            end
            model_word(first + i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
    endtask

    // scoreboard: every output transfer must match the next expected vector
    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            checks++;
            if (exp_d.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_unexpected got=%h cnt=%0d", m_data, m_count);
            end else begin
                logic [N*W-1:0] ed;
                int ec;
                ed = exp_d.pop_front();
                ec = exp_c.pop_front();
                if (m_data !== ed || m_count !== CW'(ec)) begin
                    failures++;
                    $display("FAIL scoreboard_vec got=%h/%0d want=%h/%0d", m_data, m_count, ed, ec);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b want=0", m_valid); end
        if (flush_ack !== 1'b0) begin failures++; $display("FAIL reset_flush_ack got=%b want=0", flush_ack); end
        if (m_count !== '0) begin failures++; $display("FAIL reset_m_count got=%0d want=0", m_count); end
        if (m_data !== '0) begin failures++; $display("FAIL reset_m_data got=%h want=0", m_data); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b want=1", s_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1;
            s_data  = W'(i);
            @(negedge clk);
            checks++;
            if (s_ready !== 1'b1) begin failures++; $display("FAIL stream_s_ready word=%0d got=%b want=1", i, s_ready); end
            model_word(i);
            @(posedge clk); #1;
            if (i % N == 0) begin
                checks++;
                if (m_valid !== 1'b1) begin failures++; $display("FAIL stream_latency word=%0d got=%b want=1", i, m_valid); end
            end
        end
        s_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL stream_valid_clear got=%b want=0", m_valid); end
    endtask

    task automatic test_backpressure();
        logic [N*W-1:0] held;
        m_ready = 1'b0;
        stream_words(1, 7);
        held = exp_d[0];
        s_valid = 1'b1;
        s_data  = W'(8);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin failures++; $display("FAIL bp_s_ready got=%b want=0", s_ready); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (m_valid !== 1'b1 || m_data !== held || m_count !== CW'(N)) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d want=1/%h/%0d", c, m_valid, m_data, m_count, held, N);
            end
        end
        m_ready = 1'b1;
        model_word(8);
        @(posedge clk); #1;
        s_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        logic [N*W-1:0] want;
        m_ready = 1'b1;
        stream_words(4, 1);
        stream_words(2, 1);
        flush = 1'b1;
        push_vec();
        want = exp_d[exp_d.size() - 1];
        @(posedge clk); #1;
        checks += 3;
        if (flush_ack !== 1'b1) begin failures++; $display("FAIL flush_ack got=%b want=1", flush_ack); end
        if (m_count !== CW'(2)) begin failures++; $display("FAIL flush_count got=%0d want=2", m_count); end
        if (m_data !== want) begin failures++; $display("FAIL flush_data got=%h want=%h", m_data, want); end
        flush = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (flush_ack !== 1'b0) begin failures++; $display("FAIL flush_ack_pulse got=%b want=0", flush_ack); end
        stream_words(9, 4);
        @(posedge clk); #1;
    endtask

    task automatic test_flush_empty();
        flush = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (flush_ack !== 1'b1) begin failures++; $display("FAIL flush_empty_ack got=%b want=1", flush_ack); end
        if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_empty_valid got=%b want=0", m_valid); end
        flush = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_empty_valid2 got=%b want=0", m_valid); end
    endtask

    task automatic test_flush_full();
        stream_words(21, 3);
        s_valid = 1'b1;
        s_data  = W'(24);
        flush   = 1'b1;
        model_word(24);
        @(posedge clk); #1;
        checks += 3;
        if (flush_ack !== 1'b1) begin failures++; $display("FAIL flush_full_ack got=%b want=1", flush_ack); end
        if (m_count !== CW'(N)) begin failures++; $display("FAIL flush_full_count got=%0d want=%0d", m_count, N); end
        if (m_valid !== 1'b1) begin failures++; $display("FAIL flush_full_valid got=%b want=1", m_valid); end
        s_valid = 1'b0;
        flush   = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_full_once got=%b want=0", m_valid); end
    endtask

    task automatic test_flush_blocked();
        m_ready = 1'b0;
        stream_words(31, 5);
        flush = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            checks++;
            if (flush_ack !== 1'b0) begin failures++; $display("FAIL flush_blocked_ack cyc=%0d got=%b want=0", c, flush_ack); end
        end
        push_vec();
        m_ready = 1'b1;
        @(posedge clk); #1;
        checks += 2;
        if (flush_ack !== 1'b1) begin failures++; $display("FAIL flush_unblock_ack got=%b want=1", flush_ack); end
        if (m_count !== CW'(1)) begin failures++; $display("FAIL flush_unblock_count got=%0d want=1", m_count); end
        flush = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        stream_words(41, 6);
        #2;
        rst = 1'b0;
        #1;
        checks += 3;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL rstmid_m_valid got=%b want=0", m_valid); end
        if (m_count !== '0) begin failures++; $display("FAIL rstmid_m_count got=%0d want=0", m_count); end
        if (m_data !== '0) begin failures++; $display("FAIL rstmid_m_data got=%h want=0", m_data); end
        grp.delete();
        exp_d.delete();
        exp_c.delete();
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL rstmid_s_ready got=%b want=1", s_ready); end
        m_ready = 1'b1;
        @(posedge clk); #1;
        stream_words(5, 4);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; s_data = '0; s_valid = 1'b0; flush = 1'b0; m_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_flush_empty();
        test_flush_full();
        test_flush_blocked();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_d.size() != 0) begin failures++; $display("FAIL drain got=%0d want=0 pending", exp_d.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
